// File: rtl/sccb_responder.sv
// SCCB camera-side target: decodes ID/sub-address/data phases into a byte-wide register port.
// Define SCCB_ACK_EN to drive the ACK (X) bit low on matched ID, SUB and WDATA phases.
module sccb_responder #(
   parameter logic [6:0] DeviceId   = 7'h21,
   parameter int         SyncStages = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_sio_c,
   input  logic       i_sio_d,
   output logic       o_sio_d_oe,
   output logic [7:0] o_reg_addr,
   output logic [7:0] o_reg_wdata,
   output logic       o_reg_we,
   input  logic [7:0] i_reg_rdata,
   output logic       o_busy
);

   typedef enum logic [2:0] {IDLE, ID, SUB, WDATA, RDATA, IGNORE} state_t;

   logic [SyncStages-1:0] c_sync, d_sync;
   logic                  scl, sda, scl_q, sda_q;
   logic                  scl_rise, scl_fall, start_ev, stop_ev;

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;
   logic [7:0] shift, shift_n;
   logic [7:0] tx, tx_n;
   logic [7:0] addr_n, wdata_n;
   logic       oe_n, we_n, busy_n;
   logic       id_match, ack;

   // Synchroniser preset high so a reset looks like an idle bus, not a START.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         c_sync <= '1;
         d_sync <= '1;
         scl_q  <= 1'b1;
         sda_q  <= 1'b1;
      end else begin
         c_sync <= {c_sync[SyncStages-2:0], i_sio_c};
         d_sync <= {d_sync[SyncStages-2:0], i_sio_d};
         scl_q  <= scl;
         sda_q  <= sda;
      end
   end

   assign scl      = c_sync[SyncStages-1];
   assign sda      = d_sync[SyncStages-1];
   assign scl_rise = scl & ~scl_q;
   assign scl_fall = ~scl & scl_q;
   assign start_ev = scl & scl_q & sda_q & ~sda;
   assign stop_ev  = scl & scl_q & ~sda_q & sda;
   assign id_match = (shift[7:1] == DeviceId);

`ifdef SCCB_ACK_EN
   assign ack = (cnt == 4'd8) &&
                ((state == SUB) || (state == WDATA) || ((state == ID) && id_match));
`else
   assign ack = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         shift       <= 8'd0;
         tx          <= 8'd0;
         o_sio_d_oe  <= 1'b0;
         o_reg_addr  <= 8'd0;
         o_reg_wdata <= 8'd0;
         o_reg_we    <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         shift       <= shift_n;
         tx          <= tx_n;
         o_sio_d_oe  <= oe_n;
         o_reg_addr  <= addr_n;
         o_reg_wdata <= wdata_n;
         o_reg_we    <= we_n;
         o_busy      <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shift_n = shift;
      tx_n    = tx;
      oe_n    = o_sio_d_oe;
      addr_n  = o_reg_addr;
      wdata_n = o_reg_wdata;
      we_n    = 1'b0;
      busy_n  = o_busy;

      // Bus conditions take priority over any bit edge a glitch might produce.
      if (stop_ev) begin
         state_n = IDLE;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (start_ev) begin
         state_n = ID;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b1;
      end else if (scl_rise) begin
         if (state == ID || state == SUB || state == WDATA || state == RDATA) begin
            if (cnt != 4'd8) begin
               shift_n = {shift[6:0], sda};
               cnt_n   = cnt + 4'd1;
            end else begin
               cnt_n = 4'd0;
               if (state == ID) begin
                  if (!id_match) begin
                     state_n = IGNORE;
                  end else if (shift[0]) begin
                     state_n = RDATA;
                     tx_n    = i_reg_rdata;
                  end else begin
                     state_n = SUB;
                  end
               end else if (state == SUB) begin
                  addr_n  = shift;
                  state_n = WDATA;
               end else if (state == WDATA) begin
                  wdata_n = shift;
                  we_n    = 1'b1;
                  state_n = IGNORE;
               end else begin
                  state_n = IGNORE;
               end
            end
         end
      end else if (scl_fall) begin
         // Pad changes only while scl is low so data is stable for the next rise.
         if (state == RDATA && cnt != 4'd8) begin
            oe_n = ~tx[7];
            tx_n = {tx[6:0], 1'b0};
         end else begin
            oe_n = ack;
         end
         if (state == ID && cnt == 4'd8 && !id_match) begin
            state_n = IGNORE;
         end
      end
   end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: table of write transactions, hand-written
// corner sequences, and randomized transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_sccb_responder;
   localparam int Q = 40;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       i_sio_d;
   logic       o_sio_d_oe, o_reg_we, o_busy;
   logic [7:0] o_reg_addr, o_reg_wdata, i_reg_rdata;
   logic [7:0] mem [256];

   int checks = 0;
   int errors = 0;
   int oe_cnt = 0;
   logic [15:0] sq[$];
   logic [15:0] eq[$];
   logic [7:0]  m_ptr = 8'd0;
   logic [7:0]  m_wd  = 8'd0;

   assign i_sio_d     = m_sda & ~o_sio_d_oe;
   assign i_reg_rdata = mem[o_reg_addr];

   always #5 CLK = ~CLK;

   sccb_responder dut (
      .CLK(CLK), .RST(RST), .i_sio_c(m_scl), .i_sio_d(i_sio_d),
      .o_sio_d_oe(o_sio_d_oe), .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
      .o_reg_we(o_reg_we), .i_reg_rdata(i_reg_rdata), .o_busy(o_busy)
   );

   always @(negedge CLK) begin
      if (o_reg_we) sq.push_back({o_reg_addr, o_reg_wdata});
      if (o_sio_d_oe) oe_cnt <= oe_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic m_start();
      m_sda = 1'b1; m_scl = 1'b1;
      #(2*Q) m_sda = 1'b0;
      #(2*Q) m_scl = 1'b0;
   endtask

   task automatic m_rstart();
      #Q m_sda = 1'b1;
      #Q m_scl = 1'b1;
      #(2*Q) m_sda = 1'b0;
      #(2*Q) m_scl = 1'b0;
   endtask

   task automatic m_stop();
      #Q m_sda = 1'b0;
      #Q m_scl = 1'b1;
      #(2*Q) m_sda = 1'b1;
      #(2*Q);
   endtask

   task automatic m_bit(input logic b);
      #Q m_sda = b;
      #Q m_scl = 1'b1;
      #(2*Q) m_scl = 1'b0;
   endtask

   task automatic m_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) m_bit(b[i]);
      m_bit(1'b1);
   endtask

   task automatic m_read(output logic [7:0] b, output logic na_oe);
      for (int i = 7; i >= 0; i--) begin
         #Q m_sda = 1'b1;
         #Q m_scl = 1'b1;
         #Q b[i] = i_sio_d;
         #Q m_scl = 1'b0;
      end
      #Q m_sda = 1'b1;
      #Q m_scl = 1'b1;
      #Q na_oe = o_sio_d_oe;
      #Q m_scl = 1'b0;
   endtask

   task automatic cmp_strobes(input string name);
      logic [15:0] a, e;
      chk({name, "_we_count"}, sq.size(), eq.size());
      while (sq.size() > 0 && eq.size() > 0) begin
         a = sq.pop_front();
         e = eq.pop_front();
         chk({name, "_we_addr_data"}, a, e);
      end
      sq.delete();
      eq.delete();
   endtask

   task automatic cmp_state(input string name);
      chk({name, "_addr"}, o_reg_addr, m_ptr);
      chk({name, "_wdata"}, o_reg_wdata, m_wd);
      chk({name, "_busy"}, o_busy, 0);
   endtask

   typedef struct {
      logic [7:0] b0, b1, b2;
      int         nb;
      int         exp_we;
      logic [7:0] exp_addr, exp_wdata;
      bit         no_oe;
   } vec_t;

   vec_t vt[5];

   initial begin
      logic [7:0] rb, idb, sub, dat, sub1;
      logic       na;
      logic [6:0] bad;
      int         oe0, kind, nbits;
      bit         match;

      vt[0] = '{8'h42, 8'h12, 8'h80, 3, 1, 8'h12, 8'h80, 1'b0};
      vt[1] = '{8'h42, 8'h6B, 8'h00, 2, 0, 8'h6B, 8'h80, 1'b0};
      vt[2] = '{8'h60, 8'h12, 8'h80, 3, 0, 8'h6B, 8'h80, 1'b1};
      vt[3] = '{8'h42, 8'hFF, 8'h00, 3, 1, 8'hFF, 8'h00, 1'b0};
      vt[4] = '{8'h44, 8'h01, 8'h02, 3, 0, 8'hFF, 8'h00, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      #22;
      chk("rst_oe", o_sio_d_oe, 0);
      chk("rst_we", o_reg_we, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_addr", o_reg_addr, 0);
      chk("rst_wdata", o_reg_wdata, 0);
      RST = 1'b1;
      #(4*Q);

      for (int v = 0; v < 5; v++) begin
         oe0 = oe_cnt;
         m_start();
         chk("vec_busy_after_start", o_busy, 1);
         m_byte(vt[v].b0);
         m_byte(vt[v].b1);
         if (vt[v].nb == 3) m_byte(vt[v].b2);
         m_stop();
         chk("vec_we_count", sq.size(), vt[v].exp_we);
         if (vt[v].exp_we == 1 && sq.size() == 1)
            chk("vec_we_addr_data", sq[0], {vt[v].exp_addr, vt[v].exp_wdata});
         sq.delete();
         chk("vec_addr", o_reg_addr, vt[v].exp_addr);
         chk("vec_wdata", o_reg_wdata, vt[v].exp_wdata);
         chk("vec_busy_after_stop", o_busy, 0);
         if (vt[v].no_oe) chk("vec_mismatch_oe", oe_cnt - oe0, 0);
      end
      m_ptr = 8'hFF;
      m_wd  = 8'h00;

      // 2-phase write then read back 0xA5
      mem[8'h6B] = 8'hA5;
      m_start(); m_byte(8'h42); m_byte(8'h6B); m_stop();
      m_ptr = 8'h6B;
      m_start(); m_byte(8'h43); m_read(rb, na); m_stop();
      chk("read_a5_data", rb, 8'hA5);
      chk("read_a5_na_oe", na, 0);
      cmp_strobes("read_a5");
      cmp_state("read_a5");

      // STOP after 4 bits of WDATA
      m_start(); m_byte(8'h42); m_byte(8'h20);
      m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b1);
      m_stop();
      m_ptr = 8'h20;
      cmp_strobes("abort_wdata");
      cmp_state("abort_wdata");

      // Repeated START after SUB
      m_start(); m_byte(8'h42); m_byte(8'h11);
      m_rstart(); m_byte(8'h42); m_byte(8'h11); m_byte(8'h01); m_stop();
      m_ptr = 8'h11; m_wd = 8'h01; eq.push_back(16'h1101);
      cmp_strobes("rstart");
      cmp_state("rstart");

      // Reset in the middle of a read while the pad is pulled low
      m_start(); m_byte(8'h42); m_byte(8'h55); m_stop();
      mem[8'h55] = 8'h35;
      m_start(); m_byte(8'h43);
      #(2*Q);
      chk("rst_mid_read_oe_before", o_sio_d_oe, 1);
      #3 RST = 1'b0;
      #1;
      chk("rst_mid_read_oe", o_sio_d_oe, 0);
      chk("rst_mid_read_busy", o_busy, 0);
      #20 RST = 1'b1;
      m_scl = 1'b1; m_sda = 1'b1;
      #(4*Q);
      m_ptr = 8'h00; m_wd = 8'h00;
      sq.delete();
      m_start(); m_byte(8'h42); m_byte(8'h44); m_byte(8'h77); m_stop();
      m_ptr = 8'h44; m_wd = 8'h77; eq.push_back(16'h4477);
      cmp_strobes("post_reset_write");
      cmp_state("post_reset_write");

      // Randomized transactions against the transaction-level model
      for (int t = 0; t < 24; t++) begin
         kind  = $urandom_range(0, 4);
         match = ($urandom_range(0, 3) != 0);
         sub   = 8'($urandom);
         dat   = 8'($urandom);
         bad   = 7'($urandom);
         if (bad == 7'h21) bad = 7'h22;
         idb   = match ? {7'h21, 1'b0} : {bad, 1'b0};
         oe0   = oe_cnt;
         case (kind)
            0: begin
               m_start(); m_byte(idb); m_byte(sub); m_byte(dat); m_stop();
               if (match) begin m_ptr = sub; m_wd = dat; eq.push_back({sub, dat}); end
            end
            1: begin
               m_start(); m_byte(idb); m_byte(sub); m_stop();
               if (match) m_ptr = sub;
            end
            2: begin
               idb[0] = 1'b1;
               m_start(); m_byte(idb);
               if (match) begin
                  m_read(rb, na);
                  chk("rand_read_data", rb, mem[m_ptr]);
                  chk("rand_read_na_oe", na, 0);
               end else begin
                  m_byte(dat);
               end
               m_stop();
            end
            3: begin
               nbits = $urandom_range(1, 7);
               m_start(); m_byte(idb); m_byte(sub);
               for (int i = 0; i < nbits; i++) m_bit(dat[7-i]);
               m_stop();
               if (match) m_ptr = sub;
            end
            default: begin
               sub1 = 8'($urandom);
               m_start(); m_byte(8'h42); m_byte(sub1);
               m_rstart(); m_byte(idb); m_byte(sub); m_byte(dat); m_stop();
               m_ptr = sub1;
               if (match) begin m_ptr = sub; m_wd = dat; eq.push_back({sub, dat}); end
            end
         endcase
         if (!match && kind != 4) chk("rand_mismatch_oe", oe_cnt - oe0, 0);
         cmp_strobes("rand");
         cmp_state("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
